// File: rtl/ctrl_sequencer.sv
// Cycle sequencer for the non-pipelined Harvard CPU: one-hot fetch/exec1/exec2 state, instruction
// register, run/single-step control, halt detection and retired-instruction count. Optional macro: SEQ_STALL_EN.
module ctrl_sequencer #(
  parameter int          IW      = 8,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter int          CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_en,
  input  logic            step_mode,
  input  logic            step,
  input  logic            clear_halt,
  input  logic [IW-1:0]   imem_data,
`ifdef SEQ_STALL_EN
  input  logic            imem_ready,
`endif
  output logic [2:0]      state,
  output logic [3:0]      inst,
  output logic [IW-5:0]   operand,
  output logic            halted,
  output logic [CNTW-1:0] retire_cnt
);

  // Active states share their one-hot output code; HALT uses an otherwise illegal code.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_FETCH = 3'b001;
  localparam logic [2:0] S_EXEC1 = 3'b010;
  localparam logic [2:0] S_EXEC2 = 3'b100;
  localparam logic [2:0] S_HALT  = 3'b111;

  logic [2:0]      fsm_q, fsm_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            fetch_go;
  logic            issue;

`ifdef SEQ_STALL_EN
  assign fetch_go = imem_ready;
`else
  assign fetch_go = 1'b1;
`endif

  assign issue = run_en & (~step_mode | step);

  always_comb begin
    fsm_d = fsm_q;
    ir_d  = ir_q;
    cnt_d = cnt_q;
    case (fsm_q)
      S_IDLE:  if (issue) fsm_d = S_FETCH;
      S_FETCH: if (fetch_go) begin
        ir_d  = imem_data;
        fsm_d = S_EXEC1;
      end
      S_EXEC1: fsm_d = (ir_q[IW-1 -: 4] == HALT_OP) ? S_HALT : S_EXEC2;
      S_EXEC2: begin
        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        fsm_d = (run_en && !step_mode) ? S_FETCH : S_IDLE;
      end
      S_HALT:  if (clear_halt) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  assign state      = (fsm_q == S_HALT) ? 3'b000 : fsm_q;
  assign halted     = (fsm_q == S_HALT);
  assign inst       = ir_q[IW-1 -: 4];
  assign operand    = ir_q[IW-5:0];
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en, step_mode, step, clear_halt;
  logic [7:0]  imem_data;
  logic        imem_ready;
  logic [2:0]  state,  state4;
  logic [3:0]  inst,   inst4;
  logic [3:0]  operand, operand4;
  logic        halted, halted4;
  logic [15:0] retire_cnt;
  logic [3:0]  retire_cnt4;
  logic        async_chk = 1'b0;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [3:0]  inst;
    logic [3:0]  op;
    logic        halt;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.IW(8), .HALT_OP(4'hF), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .step_mode(step_mode), .step(step),
    .clear_halt(clear_halt), .imem_data(imem_data),
`ifdef SEQ_STALL_EN
    .imem_ready(imem_ready),
`endif
    .state(state), .inst(inst), .operand(operand), .halted(halted), .retire_cnt(retire_cnt)
  );

  ctrl_sequencer #(.IW(8), .HALT_OP(4'hF), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .step_mode(step_mode), .step(step),
    .clear_halt(clear_halt), .imem_data(imem_data),
`ifdef SEQ_STALL_EN
    .imem_ready(imem_ready),
`endif
    .state(state4), .inst(inst4), .operand(operand4), .halted(halted4), .retire_cnt(retire_cnt4)
  );

  // Monitor: outputs are presented every cycle; compare just after each rising edge
  // (or just after an asynchronous reset request).
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge async_chk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (state !== e.st || inst !== e.inst || operand !== e.op || halted !== e.halt ||
            retire_cnt !== e.cnt || retire_cnt4 !== e.cnt4 || state4 !== e.st) begin
          n_fail++;
          $display("FAIL %s: got st=%b inst=%h op=%h halt=%b cnt=%0d cnt4=%0d st4=%b, want st=%b inst=%h op=%h halt=%b cnt=%0d cnt4=%0d",
                   e.name, state, inst, operand, halted, retire_cnt, retire_cnt4, state4,
                   e.st, e.inst, e.op, e.halt, e.cnt, e.cnt4);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [2:0] st, input logic [3:0] i,
                          input logic [3:0] op, input logic h, input int cnt);
    exp_t e;
    e.name = nm; e.st = st; e.inst = i; e.op = op; e.halt = h;
    e.cnt  = 16'(cnt);
    e.cnt4 = 4'(cnt % 16);
    exp_q.push_back(e);
  endtask

  // Drive inputs for one cycle and record what the outputs must be after the next edge.
  task automatic tick(input string nm, input logic r, input logic sm, input logic sp,
                      input logic clr, input logic [7:0] d, input logic [2:0] st,
                      input logic [3:0] i, input logic [3:0] op, input logic h, input int cnt);
    run_en = r; step_mode = sm; step = sp; clear_halt = clr; imem_data = d;
    push_exp(nm, st, i, op, h, cnt);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; run_en = 0; step_mode = 0; step = 0; clear_halt = 0;
    imem_data = 8'h00; imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state held while idle
    tick("reset_idle", 0,0,0,0,8'h53, 3'b000,4'h0,4'h0,0,0);

    // Free run on 0x53; run_en drops during the third instruction, which still completes
    tick("run_fetch", 1,0,0,0,8'h53, 3'b001,4'h0,4'h0,0,0);
    for (int i = 0; i < 3; i++) begin
      logic r;
      r = (i < 2);
      tick("run_exec1", r,0,0,0,8'h53, 3'b010,4'h5,4'h3,0,i);
      tick("run_exec2", r,0,0,0,8'h53, 3'b100,4'h5,4'h3,0,i);
      tick("run_retire", r,0,0,0,8'h53, (i < 2) ? 3'b001 : 3'b000,4'h5,4'h3,0,i+1);
    end
    tick("run_parked", 0,0,0,0,8'h53, 3'b000,4'h5,4'h3,0,3);

    // Single step on 0x2A; stray steps in EXEC1/EXEC2 are dropped
    tick("step_wait", 1,1,0,0,8'h2A, 3'b000,4'h5,4'h3,0,3);
    for (int k = 0; k < 3; k++) begin
      tick("step_fetch", 1,1,1,0,8'h2A, 3'b001,(k==0)?4'h5:4'h2,(k==0)?4'h3:4'hA,0,3+k);
      tick("step_exec1", 1,1,0,0,8'h2A, 3'b010,4'h2,4'hA,0,3+k);
      tick("step_exec2", 1,1,(k==1),0,8'h2A, 3'b100,4'h2,4'hA,0,3+k);
      tick("step_idle", 1,1,(k==2),0,8'h2A, 3'b000,4'h2,4'hA,0,4+k);
      tick("step_gap1", 1,1,0,0,8'h2A, 3'b000,4'h2,4'hA,0,4+k);
      tick("step_gap2", 1,1,0,0,8'h2A, 3'b000,4'h2,4'hA,0,4+k);
    end

    // Halt opcode: not retired, run/step ignored, clear_halt releases to IDLE
    tick("halt_fetch", 1,0,0,0,8'hF0, 3'b001,4'h2,4'hA,0,6);
    tick("halt_exec1", 1,0,0,0,8'hF0, 3'b010,4'hF,4'h0,0,6);
    tick("halt_enter", 1,0,0,0,8'h53, 3'b000,4'hF,4'h0,1,6);
    tick("halt_run0",  0,0,0,0,8'h53, 3'b000,4'hF,4'h0,1,6);
    tick("halt_step",  1,1,1,0,8'h53, 3'b000,4'hF,4'h0,1,6);
    tick("halt_clear", 1,0,0,1,8'h53, 3'b000,4'hF,4'h0,0,6);
    tick("post_fetch", 1,0,0,0,8'h53, 3'b001,4'hF,4'h0,0,6);
    tick("post_exec1", 1,0,0,0,8'h53, 3'b010,4'h5,4'h3,0,6);
    tick("post_exec2", 1,0,0,0,8'h53, 3'b100,4'h5,4'h3,0,6);
    tick("clr_ignored",1,0,0,1,8'h53, 3'b001,4'h5,4'h3,0,7);
    tick("pre_rst_ex1",1,0,0,0,8'h53, 3'b010,4'h5,4'h3,0,7);

    // Asynchronous reset in EXEC1, observed before any clock edge
    #2;
    rst_n = 1'b0;
    push_exp("async_reset", 3'b000,4'h0,4'h0,0,0);
    async_chk = 1'b1;
    #1 async_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from IDLE, then 17 back-to-back instructions to wrap the 4-bit counter
    tick("rst_fetch", 1,0,0,0,8'h53, 3'b001,4'h0,4'h0,0,0);
    for (int j = 0; j < 17; j++) begin
      logic r;
      r = (j < 16);
      tick("wrap_exec1", r,0,0,0,8'h53, 3'b010,4'h5,4'h3,0,j);
      tick("wrap_exec2", r,0,0,0,8'h53, 3'b100,4'h5,4'h3,0,j);
      tick("wrap_retire", r,0,0,0,8'h53, (j < 16) ? 3'b001 : 3'b000,4'h5,4'h3,0,j+1);
    end
    tick("wrap_parked", 0,0,0,0,8'h53, 3'b000,4'h5,4'h3,0,17);

    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
